// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type and default sizing for the multi-port register file
package regfile_pkg;
  typedef enum logic {IDLE, CLEAR} state_e;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_READ_PORTS = 2;
  localparam int DEF_BYPASS = 1;
endpackage

// File: rtl/register_file_mp_if.sv
// register_file_mp_if: read, write, pending and sweep-control signals of the register file
interface register_file_mp_if #(
  parameter int DATA_WIDTH = regfile_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::DEF_ADDR_WIDTH,
  parameter int READ_PORTS = regfile_pkg::DEF_READ_PORTS
) ();
  logic                             clk_enable;
  logic [READ_PORTS*ADDR_WIDTH-1:0] read_reg;
  logic [READ_PORTS*DATA_WIDTH-1:0] read_data;
  logic [READ_PORTS-1:0]            read_pending;
  logic                             reg_write_enable;
  logic [ADDR_WIDTH-1:0]            write_reg_rd;
  logic [DATA_WIDTH-1:0]            reg_write_data;
  logic [DATA_WIDTH/8-1:0]          write_byte_en;
  logic                             pending_set;
  logic [ADDR_WIDTH-1:0]            pending_reg;
  logic                             clear_req;
  logic                             busy;
  logic                             clear_done;
  modport master (
    output clk_enable, read_reg, reg_write_enable, write_reg_rd, reg_write_data,
           write_byte_en, pending_set, pending_reg, clear_req,
    input  read_data, read_pending, busy, clear_done
  );
  modport slave (
    input  clk_enable, read_reg, reg_write_enable, write_reg_rd, reg_write_data,
           write_byte_en, pending_set, pending_reg, clear_req,
    output read_data, read_pending, busy, clear_done
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register outstanding-load bits with set, write-clear, sweep-clear and read lookup
module regfile_scoreboard #(
  parameter int ADDR_WIDTH = regfile_pkg::DEF_ADDR_WIDTH,
  parameter int READ_PORTS = regfile_pkg::DEF_READ_PORTS
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             set_i,
  input  logic [ADDR_WIDTH-1:0]            set_idx_i,
  input  logic                             clr_i,
  input  logic [ADDR_WIDTH-1:0]            clr_idx_i,
  input  logic                             wipe_i,
  input  logic [ADDR_WIDTH-1:0]            wipe_idx_i,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_idx_i,
  output logic [READ_PORTS-1:0]            pend_o
);
  localparam int REG_COUNT = 2**ADDR_WIDTH;
  logic [REG_COUNT-1:0] pending_q, pending_d;
  // set is applied last so it wins over a same-cycle write to the same index
  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_idx_i] = 1'b0;
    if (wipe_i) pending_d[wipe_idx_i] = 1'b0;
    if (set_i && set_idx_i != '0) pending_d[set_idx_i] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pending_q <= '0;
    else pending_q <= pending_d;
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    assign pend_o[p] = pending_q[rd_idx_i[p*ADDR_WIDTH +: ADDR_WIDTH]];
  end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: flop-based multi-read-port register file with byte-masked writes, forwarding and soft-clear sweep
module register_file_mp #(
  parameter int DATA_WIDTH = regfile_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::DEF_ADDR_WIDTH,
  parameter int READ_PORTS = regfile_pkg::DEF_READ_PORTS,
  parameter int BYPASS     = regfile_pkg::DEF_BYPASS
) (
  input logic               clk,
  input logic               reset_n,
  register_file_mp_if.slave bus
);
  import regfile_pkg::*;
  localparam int REG_COUNT = 2**ADDR_WIDTH;
  localparam int NB = DATA_WIDTH/8;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  clear_done_q;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] merged;
  logic                  busy, wr_commit, sweep_en, sweep_last;
  assign busy       = state_q == CLEAR;
  assign wr_commit  = bus.clk_enable && bus.reg_write_enable && !busy && bus.write_reg_rd != '0;
  assign sweep_en   = bus.clk_enable && busy;
  assign sweep_last = sweep_en && idx_q == ADDR_WIDTH'(REG_COUNT - 1);
  assign bus.busy       = busy;
  assign bus.clear_done = clear_done_q;
  for (genvar b = 0; b < NB; b++) begin : g_mrg
    assign merged[b*8 +: 8] = bus.write_byte_en[b] ? bus.reg_write_data[b*8 +: 8]
                                                   : regs_q[bus.write_reg_rd][b*8 +: 8];
  end
  // register 0 never gets written, so its flops stay at the reset value of zero
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = bus.read_reg[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] =
      (BYPASS != 0 && wr_commit && bus.write_reg_rd == ra) ? merged : regs_q[ra];
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (bus.clk_enable && state_q == IDLE && bus.clear_req) begin
      state_d = CLEAR;
      idx_d   = '0;
    end else if (sweep_en) begin
      state_d = sweep_last ? IDLE : CLEAR;
      idx_d   = idx_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      clear_done_q <= sweep_last;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    else if (sweep_en) regs_q[idx_q] <= '0;
    else if (wr_commit) regs_q[bus.write_reg_rd] <= merged;
  regfile_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH), .READ_PORTS(READ_PORTS)) u_sb (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_i      (bus.clk_enable && bus.pending_set && !busy),
    .set_idx_i  (bus.pending_reg),
    .clr_i      (wr_commit),
    .clr_idx_i  (bus.write_reg_rd),
    .wipe_i     (sweep_en),
    .wipe_idx_i (idx_q),
    .rd_idx_i   (bus.read_reg),
    .pend_o     (bus.read_pending)
  );
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed and random stimulus scored against a behavioural register-file model
module tb_register_file_mp;
  localparam int DW = 32, AW = 5, RP = 3, NR = 32;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  register_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP)) bus ();
  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [RP*DW-1:0] rd;
    logic [RP-1:0]    pend;
    logic             busy;
    logic             done;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  logic [DW-1:0] mreg [NR];
  bit mpend [NR];
  int sweep_pos = -1;
  bit mdone = 0;
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[b*8 +: 8] = nw[b*8 +: 8];
  endfunction
  task automatic cyc(input bit rn, input bit en, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [3:0] be, input bit ps, input logic [4:0] pr, input bit cr,
                     input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    logic [4:0] ra [RP];
    logic [DW-1:0] d;
    bit done_n;
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    @(negedge clk);
    reset_n = rn;
    bus.clk_enable = en; bus.reg_write_enable = we; bus.write_reg_rd = wa;
    bus.reg_write_data = wd; bus.write_byte_en = be; bus.pending_set = ps;
    bus.pending_reg = pr; bus.clear_req = cr; bus.read_reg = {r2, r1, r0};
    if (!rn) begin
      for (int i = 0; i < NR; i++) begin mreg[i] = '0; mpend[i] = 0; end
      sweep_pos = -1;
      mdone = 0;
    end
    for (int p = 0; p < RP; p++) begin
      d = mreg[ra[p]];
      if (rn && en && we && sweep_pos < 0 && wa != 0 && wa == ra[p]) d = merge(mreg[wa], wd, be);
      e.rd[p*DW +: DW] = d;
      e.pend[p] = mpend[ra[p]];
    end
    e.busy = sweep_pos >= 0;
    e.done = mdone;
    q.push_back(e);
    if (rn) begin
      done_n = 0;
      if (en && sweep_pos < 0) begin
        if (we && wa != 0) begin mreg[wa] = merge(mreg[wa], wd, be); mpend[wa] = 0; end
        if (ps && pr != 0) mpend[pr] = 1;
        if (cr) sweep_pos = 0;
      end else if (en) begin
        mreg[sweep_pos] = '0;
        mpend[sweep_pos] = 0;
        if (sweep_pos == NR - 1) begin sweep_pos = -1; done_n = 1; end
        else sweep_pos++;
      end
      mdone = done_n;
    end
  endtask
  task automatic rst();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic idle(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, r0, r1, r2);
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be, input logic [4:0] r0);
    cyc(1, 1, 1, a, d, be, 0, 0, 0, r0, a, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int p = 0; p < RP; p++) begin
          vectors++;
          if (bus.read_data[p*DW +: DW] !== e.rd[p*DW +: DW]) begin
            miscompares++;
            $display("FAIL read_data[%0d] t=%0t got %h exp %h", p, $time, bus.read_data[p*DW +: DW], e.rd[p*DW +: DW]);
          end
        end
        vectors++;
        if (bus.read_pending !== e.pend) begin
          miscompares++;
          $display("FAIL read_pending t=%0t got %b exp %b", $time, bus.read_pending, e.pend);
        end
        vectors++;
        if (bus.busy !== e.busy) begin
          miscompares++;
          $display("FAIL busy t=%0t got %b exp %b", $time, bus.busy, e.busy);
        end
        vectors++;
        if (bus.clear_done !== e.done) begin
          miscompares++;
          $display("FAIL clear_done t=%0t got %b exp %b", $time, bus.clear_done, e.done);
        end
      end
    end
  end
  initial begin
    int guard;
    logic [4:0] wa;
    bus.clk_enable = 0; bus.reg_write_enable = 0; bus.write_reg_rd = '0; bus.reg_write_data = '0;
    bus.write_byte_en = '0; bus.pending_set = 0; bus.pending_reg = '0; bus.clear_req = 0; bus.read_reg = '0;
    rst();
    rst();
    idle(0, 5, 7);
    wr(5, 32'hDEADBEEF, 4'hF, 0);
    idle(5, 0, 0);
    wr(7, 32'h11223344, 4'hF, 0);
    wr(7, 32'hAABBCCDD, 4'h3, 7);
    idle(7, 5, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 9, 0, 9, 0, 0);
    idle(9, 0, 0);
    wr(9, 32'h00001234, 4'hF, 9);
    idle(9, 0, 0);
    cyc(1, 1, 1, 9, 32'h00005555, 4'hF, 1, 9, 0, 9, 0, 0);
    idle(9, 9, 0);
    cyc(1, 1, 1, 0, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    for (int i = 1; i < NR; i++) cyc(1, 1, 1, 5'(i), 32'h80000000 | (32'h01010101 * i), 4'hF, i % 3 == 0, 5'(NR - i), 0, 5'(i), 5'(i - 1), 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 3, 31, 1);
    guard = 0;
    while (sweep_pos >= 0 && guard < 100) begin
      cyc(1, guard % 5 != 4, 1, 5'($urandom_range(1, 31)), $urandom, 4'hF, 1, 5'($urandom_range(1, 31)), 1,
          5'($urandom), 5'($urandom), 5'($urandom));
      guard++;
    end
    for (int i = 0; i < 11; i++) idle(5'(3*i), 5'(3*i + 1), 5'(3*i + 2));
    for (int i = 1; i < 6; i++) cyc(1, 1, 1, 5'(i), 32'hCAFE0000 + i, 4'hF, 1, 5'(i + 8), 0, 5'(i), 5'(i + 8), 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 9);
    for (int i = 0; i < 10; i++) idle(5'(i), 5'(i + 10), 5'(i + 20));
    rst();
    idle(1, 9, 10);
    wr(0, 32'hFFFFFFFF, 4'hF, 0);
    idle(0, 1, 2);
    for (int i = 0; i < 1000; i++) begin
      wa = 5'($urandom);
      cyc(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1), wa, $urandom, 4'($urandom), $urandom_range(0, 3) == 0,
          5'($urandom), $urandom_range(0, 99) == 0, ($urandom_range(0, 2) == 0) ? wa : 5'($urandom), 5'($urandom), 5'($urandom));
    end
    @(negedge clk);
    #5;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d left exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, as the register width in bits (must be a multiple of 8).
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 5, as the register index width; REG_COUNT = 2**ADDR_WIDTH.
REQ-003 The block SHALL take parameter READ_PORTS, default 2, as the number of independent read ports (1..4).
REQ-004 The block SHALL take parameter BYPASS, default 1, where 1 enables same-cycle write-to-read forwarding.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 clk_enable  input  1  global stall; 0 freezes all state except reset.
REQ-008 read_reg  input  READ_PORTS*ADDR_WIDTH  packed read indices; port p occupies slice p.
REQ-009 read_data  output  READ_PORTS*DATA_WIDTH  packed read data, combinational.
REQ-010 read_pending  output  READ_PORTS  1 = the indexed register has an outstanding load.
REQ-011 reg_write_enable  input  1  write request.
REQ-012 write_reg_rd  input  ADDR_WIDTH  write index.
REQ-013 reg_write_data  input  DATA_WIDTH  write data.
REQ-014 write_byte_en  input  DATA_WIDTH/8  per-byte write mask (generalises LWL/LWR merge).
REQ-015 pending_set  input  1  mark pending_reg as awaiting a load result.
REQ-016 pending_reg  input  ADDR_WIDTH  index to mark pending.
REQ-017 clear_req  input  1  start a soft-clear sweep.
REQ-018 busy  output  1  1 while the soft-clear sweep is running.
REQ-019 clear_done  output  1  one-cycle pulse on the cycle the sweep finishes.

Function
REQ-020 Register 0 SHALL always read 0 and ignore writes and pending_set.
REQ-021 A write SHALL commit on the rising edge when clk_enable=1, reg_write_enable=1, busy=0; only bytes with write_byte_en[b]=1 change, other bytes keep their old value.
REQ-022 read_data slice p SHALL equal the stored value of read_reg slice p; with BYPASS=1 and a committing write to the same nonzero index in that cycle, the merged (old/new per byte mask) value SHALL be forwarded instead.
REQ-023 A committing write to index i SHALL clear pending[i] at that edge; pending_set with clk_enable=1 SHALL set pending[pending_reg].
REQ-024 When a write and pending_set target the same index in the same cycle, pending SHALL end set (set wins).
REQ-025 read_pending[p] SHALL equal pending[read_reg slice p], unaffected by same-cycle writes.
REQ-026 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clear_req=1 with clk_enable=1, loading sweep index 0.
REQ-027 In CLEAR, each enabled cycle SHALL zero register[index] and pending[index], then increment index; stalled cycles hold index.
REQ-028 On the enabled cycle that clears index REG_COUNT-1 the FSM SHALL return to IDLE and assert clear_done for exactly that following cycle; sweep takes REG_COUNT enabled cycles.
REQ-029 busy SHALL be 1 exactly while in CLEAR; writes and pending_set arriving while busy=1 SHALL be dropped (no queueing).
REQ-030 clear_req while busy=1 SHALL be ignored (no restart).

Reset
REQ-031 reset_n=0 SHALL asynchronously zero all registers, all pending bits, the sweep index, busy and clear_done, and force IDLE.
REQ-032 reset_n low mid-sweep SHALL abort the sweep; no clear_done pulse follows.
REQ-033 After release, first state change SHALL occur on the first rising edge with reset_n=1.

Structure
REQ-034 Package regfile_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-035 Pending-bit tracking SHALL be a sub-module regfile_scoreboard (set/clear/clear-all-by-index, READ_PORTS lookup).
REQ-036 Storage SHALL be flip-flops (no RAM inference) so reset and sweep clearing are legal.

Verification
REQ-037 Write 0xDEADBEEF to r5, byte_en=1111, read port0=r5 next cycle -> read_data=0xDEADBEEF.
REQ-038 r7=0x11223344, then write 0xAABBCCDD with byte_en=0011 -> r7 reads 0x1122CCDD; same-cycle read with BYPASS=1 also shows 0x1122CCDD.
REQ-039 pending_set r9, then write r9 -> read_pending goes 1 then 0; simultaneous write+pending_set r9 -> stays 1.
REQ-040 Fill r1..r31 nonzero, pulse clear_req -> busy=1 for 32 enabled cycles, clear_done pulses once, all reads 0; writes during busy dropped.
REQ-041 Drop reset_n at sweep index 10 -> all state 0, busy=0, no clear_done; write r0=0xFFFFFFFF -> r0 reads 0.
REQ-042 Random 1000-cycle run (random clk_enable, writes, masks, 1% clear_req) against shadow model with 3 read ports -> zero mismatches.
